cdb_arbiter: RTL and testbench

Shares NUM_CDB common-data-bus broadcast slots among NUM_REQ functional-unit writeback requesters (add, mul, div, br, mem). Each cycle it grants up to NUM_CDB requesters, oldest-first by ROB age relative to the ROB head, with starvation escalation. Granted results are registered onto the CDB one cycle later, where they feed the ROB commit-mark inputs, reservation-station wakeup and the physical regfile write port.

---
 rtl/cdb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares NUM_CDB common-data-bus broadcast slots among NUM_REQ functional-unit
//   writeback requesters (0=add, 1=mul, 2=div, 3=br, 4=mem). Each cycle up to
//   NUM_CDB valid requesters are granted. Grants are made oldest-first by ROB
//   age relative to rob_head. A requester left waiting STARVE_LIMIT cycles
//   escalates ahead of every non-starving requester. Granted payloads appear on
//   the cdb_* registers one cycle later.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   flush          branch-mispredict flush: no grants, counters cleared,
//                  no broadcast next cycle
//   rob_head       ROB index of the oldest uncommitted entry
//   req_valid      per-requester "result available"
//   req_rob_idx    per-requester ROB index   (slice i = [i*IDX_W +: IDX_W])
//   req_pd         per-requester dest preg   (slice i = [i*PD_W +: PD_W])
//   req_data       per-requester result      (slice i = [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready      combinational grant, same cycle as req_valid
//   cdb_valid      registered per-slot broadcast valid
//   cdb_rob_idx    registered per-slot ROB index
//   cdb_pd         registered per-slot dest preg
//   cdb_data       registered per-slot result
//   cdb_src        registered per-slot owning requester index
module cdb_arbiter #(
  parameter int NUM_REQ      = 5,
  parameter int NUM_CDB      = 2,
  parameter int QUEUE_DEPTH  = 64,
  parameter int PD_W         = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8,
  localparam int IDX_W = $clog2(QUEUE_DEPTH),
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [IDX_W-1:0]              rob_head,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]      req_rob_idx,
  input  logic [NUM_REQ*PD_W-1:0]       req_pd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_CDB-1:0]            cdb_valid,
  output logic [NUM_CDB*IDX_W-1:0]      cdb_rob_idx,
  output logic [NUM_CDB*PD_W-1:0]       cdb_pd,
  output logic [NUM_CDB*DATA_WIDTH-1:0] cdb_data,
  output logic [NUM_CDB*SRC_W-1:0]      cdb_src
);

  // Sort key {!starving, age, index}: smaller is higher priority. Including
  // the index makes every key unique, so ranks are a strict total order.
  localparam int KEY_W  = 1 + IDX_W + SRC_W;
  localparam int RANK_W = $clog2(NUM_REQ + 1);

  logic [CNT_W-1:0]  wait_cnt_reg [NUM_REQ];
  logic [NUM_REQ-1:0] starving;
  logic [IDX_W-1:0]  age  [NUM_REQ];
  logic [KEY_W-1:0]  key  [NUM_REQ];
  logic [RANK_W-1:0] rank [NUM_REQ];
  logic [NUM_REQ-1:0] grant;

  logic [NUM_CDB-1:0]            slot_used_next;
  logic [NUM_CDB*IDX_W-1:0]      slot_rob_next;
  logic [NUM_CDB*PD_W-1:0]       slot_pd_next;
  logic [NUM_CDB*DATA_WIDTH-1:0] slot_data_next;
  logic [NUM_CDB*SRC_W-1:0]      slot_src_next;

  logic [NUM_CDB-1:0]            cdb_valid_reg;
  logic [NUM_CDB*IDX_W-1:0]      cdb_rob_idx_reg;
  logic [NUM_CDB*PD_W-1:0]       cdb_pd_reg;
  logic [NUM_CDB*DATA_WIDTH-1:0] cdb_data_reg;
  logic [NUM_CDB*SRC_W-1:0]      cdb_src_reg;

  // Per-requester age, starvation flag, key and grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    localparam logic [SRC_W-1:0] SELF = SRC_W'(gi);
    // Modulo-QUEUE_DEPTH distance from the head; wraps naturally in IDX_W bits.
    assign age[gi]      = req_rob_idx[gi*IDX_W +: IDX_W] - rob_head;
    assign starving[gi] = (wait_cnt_reg[gi] == CNT_W'(STARVE_LIMIT));
    assign key[gi]      = {~starving[gi], age[gi], SELF};
    // Rank counts only valid competitors, so rank < NUM_CDB means "in the
    // top NUM_CDB" among valid requesters.
    assign grant[gi]    = req_valid[gi] && (rank[gi] < RANK_W'(NUM_CDB)) &&
                          !flush && !rst;
  end

  assign req_ready = grant;

  // Rank of each requester = number of valid requesters with a smaller key.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rank[i] = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j != i && req_valid[j] && (key[j] < key[i])) begin
          rank[i] = rank[i] + RANK_W'(1);
        end
      end
    end
  end

  // Slot k takes the valid requester of rank k. Ranks are unique, so at most
  // one requester matches each slot and no requester can occupy two slots.
  always_comb begin
    slot_used_next = '0;
    slot_rob_next  = '0;
    slot_pd_next   = '0;
    slot_data_next = '0;
    slot_src_next  = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && (rank[i] == RANK_W'(k))) begin
          slot_used_next[k]                        = 1'b1;
          slot_rob_next[k*IDX_W +: IDX_W]          = req_rob_idx[i*IDX_W +: IDX_W];
          slot_pd_next[k*PD_W +: PD_W]             = req_pd[i*PD_W +: PD_W];
          slot_data_next[k*DATA_WIDTH +: DATA_WIDTH] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
          slot_src_next[k*SRC_W +: SRC_W]          = SRC_W'(i);
        end
      end
    end
  end

  // Starvation counters: count ungranted valid cycles, saturate at the limit.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_cnt_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || grant[i]) begin
          wait_cnt_reg[i] <= '0;
        end else if (!starving[i]) begin
          wait_cnt_reg[i] <= wait_cnt_reg[i] + CNT_W'(1);
        end
      end
    end
  end

  // Broadcast registers. Payloads only load for used slots and otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_reg   <= '0;
      cdb_rob_idx_reg <= '0;
      cdb_pd_reg      <= '0;
      cdb_data_reg    <= '0;
      cdb_src_reg     <= '0;
    end else begin
      cdb_valid_reg <= flush ? '0 : slot_used_next;
      for (int k = 0; k < NUM_CDB; k++) begin
        if (slot_used_next[k] && !flush) begin
          cdb_rob_idx_reg[k*IDX_W +: IDX_W]          <= slot_rob_next[k*IDX_W +: IDX_W];
          cdb_pd_reg[k*PD_W +: PD_W]                 <= slot_pd_next[k*PD_W +: PD_W];
          cdb_data_reg[k*DATA_WIDTH +: DATA_WIDTH]   <= slot_data_next[k*DATA_WIDTH +: DATA_WIDTH];
          cdb_src_reg[k*SRC_W +: SRC_W]              <= slot_src_next[k*SRC_W +: SRC_W];
        end
      end
    end
  end

  assign cdb_valid   = cdb_valid_reg;
  assign cdb_rob_idx = cdb_rob_idx_reg;
  assign cdb_pd      = cdb_pd_reg;
  assign cdb_data    = cdb_data_reg;
  assign cdb_src     = cdb_src_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter with default parameters
// (5 requesters, 2 slots, 64-entry ROB, starvation limit 8).
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [5:0]   rob_head;
  logic [4:0]   req_valid;
  logic [29:0]  req_rob_idx;
  logic [29:0]  req_pd;
  logic [159:0] req_data;
  logic [4:0]   req_ready;
  logic [1:0]   cdb_valid;
  logic [11:0]  cdb_rob_idx;
  logic [11:0]  cdb_pd;
  logic [63:0]  cdb_data;
  logic [5:0]   cdb_src;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .rob_head    (rob_head),
    .req_valid   (req_valid),
    .req_rob_idx (req_rob_idx),
    .req_pd      (req_pd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cdb_valid   (cdb_valid),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_pd      (cdb_pd),
    .cdb_data    (cdb_data),
    .cdb_src     (cdb_src)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [5:0] idx, input logic [5:0] pd,
                         input logic [31:0] data);
    req_valid[i]          = 1'b1;
    req_rob_idx[i*6 +: 6] = idx;
    req_pd[i*6 +: 6]      = pd;
    req_data[i*32 +: 32]  = data;
  endtask

  // Advance past the next rising edge; sampling 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rob_head = '0;
    req_valid = '0; req_rob_idx = '0; req_pd = '0; req_data = '0;

    // ---- Reset with all requesters valid ----
    set_req(0, 6'd1, 6'd1, 32'h11);
    set_req(1, 6'd2, 6'd2, 32'h22);
    set_req(2, 6'd3, 6'd3, 32'h33);
    set_req(3, 6'd4, 6'd4, 32'h44);
    set_req(4, 6'd5, 6'd5, 32'h55);
    #1; chk("rst1_ready", req_ready, 5'b00000);
    tick();
    chk("rst1_cdb_valid", cdb_valid, 2'b00);
    chk("rst1_cdb_idx", cdb_rob_idx, 12'd0);
    chk("rst1_cdb_data", cdb_data, 64'd0);
    chk("rst1_cdb_src", cdb_src, 6'd0);
    #1; chk("rst2_ready", req_ready, 5'b00000);
    tick();
    chk("rst2_cdb_valid", cdb_valid, 2'b00);
    $display("txn reset: ready=%b cdb_valid=%b", req_ready, cdb_valid);
    rst = 1'b0; req_valid = '0;
    #1;
    chk("post_rst_ready", req_ready, 5'b00000);
    chk("post_rst_cdb_valid", cdb_valid, 2'b00);
    tick();
    chk("post_rst_cdb_valid2", cdb_valid, 2'b00);

    // ---- Age order: head 10, add 14 (age 4), mul 11 (age 1), div 20 (age 10) ----
    rob_head = 6'd10;
    set_req(0, 6'd14, 6'd1, 32'h100);
    set_req(1, 6'd11, 6'd2, 32'h200);
    set_req(2, 6'd20, 6'd3, 32'h300);
    #1; chk("age_ready", req_ready, 5'b00011);
    tick();
    chk("age_cdb_valid", cdb_valid, 2'b11);
    chk("age_cdb_idx", cdb_rob_idx, {6'd14, 6'd11});
    chk("age_cdb_src", cdb_src, {3'd0, 3'd1});
    chk("age_cdb_pd", cdb_pd, {6'd1, 6'd2});
    chk("age_cdb_data", cdb_data, {32'h100, 32'h200});
    $display("txn age: cdb_idx=%0d/%0d src=%0d/%0d", cdb_rob_idx[5:0], cdb_rob_idx[11:6],
             cdb_src[2:0], cdb_src[5:3]);
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    #1; chk("age_div_ready", req_ready, 5'b00100);
    tick();
    chk("age_div_cdb_valid", cdb_valid, 2'b01);
    chk("age_div_cdb_idx", cdb_rob_idx[5:0], 6'd20);
    chk("age_div_cdb_src", cdb_src[2:0], 3'd2);
    $display("txn age_div: cdb_valid=%b idx=%0d", cdb_valid, cdb_rob_idx[5:0]);
    req_valid = '0;

    // ---- Wrap-around: head 62, br 1 (age 3), mem 63 (age 1), add 5 (age 7) ----
    rob_head = 6'd62;
    set_req(3, 6'd1,  6'd4, 32'h400);
    set_req(4, 6'd63, 6'd5, 32'h500);
    set_req(0, 6'd5,  6'd6, 32'h600);
    #1; chk("wrap_ready", req_ready, 5'b11000);
    tick();
    chk("wrap_cdb_valid", cdb_valid, 2'b11);
    chk("wrap_cdb_idx", cdb_rob_idx, {6'd1, 6'd63});
    chk("wrap_cdb_src", cdb_src, {3'd3, 3'd4});
    $display("txn wrap: cdb_idx=%0d/%0d src=%0d/%0d", cdb_rob_idx[5:0], cdb_rob_idx[11:6],
             cdb_src[2:0], cdb_src[5:3]);
    req_valid[3] = 1'b0; req_valid[4] = 1'b0;
    #1; chk("wrap_add_ready", req_ready, 5'b00001);
    tick();
    chk("wrap_add_cdb_idx", cdb_rob_idx[5:0], 6'd5);
    chk("wrap_add_cdb_src", cdb_src[2:0], 3'd0);
    req_valid = '0;

    // ---- Starvation: div at age 40 vs younger add/mul every cycle ----
    rob_head = 6'd0;
    set_req(2, 6'd40, 6'd7, 32'h700);
    for (int c = 1; c <= 8; c++) begin
      set_req(0, 6'(c % 3),     6'd8, 32'(c));
      set_req(1, 6'(3 + c % 3), 6'd9, 32'(c + 100));
      #1; chk($sformatf("starve_c%0d_ready", c), req_ready, 5'b00011);
      tick();
      chk($sformatf("starve_c%0d_src", c), cdb_src, {3'd1, 3'd0});
      $display("txn starve c%0d: ready=%b src=%0d/%0d", c, req_ready, cdb_src[2:0], cdb_src[5:3]);
    end
    set_req(0, 6'd0, 6'd8, 32'd9);
    set_req(1, 6'd3, 6'd9, 32'd109);
    #1; chk("starve_c9_ready", req_ready, 5'b00101);
    tick();
    chk("starve_c9_src", cdb_src, {3'd0, 3'd2});
    chk("starve_c9_idx", cdb_rob_idx, {6'd0, 6'd40});
    $display("txn starve c9: src=%0d/%0d", cdb_src[2:0], cdb_src[5:3]);
    req_valid[2] = 1'b0;
    set_req(0, 6'd1, 6'd8, 32'd10);
    set_req(1, 6'd4, 6'd9, 32'd110);
    #1; chk("starve_c10_ready", req_ready, 5'b00011);
    tick();
    set_req(2, 6'd40, 6'd7, 32'h700);
    set_req(0, 6'd2, 6'd8, 32'd11);
    set_req(1, 6'd5, 6'd9, 32'd111);
    #1; chk("starve_c11_ready", req_ready, 5'b00011);
    tick();
    req_valid = '0;

    // ---- Flush ----
    set_req(0, 6'd3, 6'd10, 32'h33);
    #1; chk("flush_n_ready", req_ready, 5'b00001);
    tick();
    chk("flush_n_cdb_valid", cdb_valid, 2'b01);
    req_valid[0] = 1'b0;
    set_req(1, 6'd8, 6'd11, 32'h88);
    flush = 1'b1;
    #1;
    chk("flush_n1_ready", req_ready, 5'b00000);
    chk("flush_n1_cdb_valid", cdb_valid, 2'b01);
    chk("flush_n1_cdb_idx", cdb_rob_idx[5:0], 6'd3);
    tick();
    chk("flush_n2_cdb_valid", cdb_valid, 2'b00);
    $display("txn flush: cdb_valid after flush=%b", cdb_valid);
    flush = 1'b0;
    #1; chk("flush_after_ready", req_ready, 5'b00010);
    tick();
    chk("flush_after_cdb_valid", cdb_valid, 2'b01);
    chk("flush_after_cdb_idx", cdb_rob_idx[5:0], 6'd8);
    req_valid = '0;

    // ---- Underload: only mem ----
    set_req(4, 6'd7, 6'd12, 32'hDEADBEEF);
    #1; chk("under_ready", req_ready, 5'b10000);
    tick();
    chk("under_cdb_valid", cdb_valid, 2'b01);
    chk("under_cdb_data", cdb_data[31:0], 32'hDEADBEEF);
    chk("under_cdb_pd", cdb_pd[5:0], 6'd12);
    chk("under_cdb_src", cdb_src[2:0], 3'd4);
    $display("txn underload: data=%h pd=%0d src=%0d", cdb_data[31:0], cdb_pd[5:0], cdb_src[2:0]);
    req_valid = '0;

    // ---- Reset mid-operation discards the pending grant ----
    set_req(0, 6'd1, 6'd13, 32'h77);
    rst = 1'b1;
    #1; chk("midrst_ready", req_ready, 5'b00000);
    tick();
    chk("midrst_cdb_valid", cdb_valid, 2'b00);
    $display("txn midrst: cdb_valid=%b", cdb_valid);
    rst = 1'b0;
    req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
